// File: rtl/hex_display_pager.sv
// Pages a DIGITS-nibble window across a captured DATA_W-bit value for the 7-segment decoders.
// state  | meaning
// EMPTY  | nothing held, every digit blanked
// HOLD   | value shown, window moves only on step
// SCROLL | value shown, window also moves every TICK_DIV cycles
module hex_display_pager #(
   parameter int DATA_W   = 64,
   parameter int DIGITS   = 6,
   parameter int TICK_DIV = 50000000,
   localparam int N       = DATA_W / 4,
   localparam int PW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  clear,
   input  logic                  step,
   input  logic                  auto_scroll,
   output logic [4*DIGITS-1:0]   hex_digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic [PW-1:0]         window_pos,
   output logic                  loaded
);

   localparam int TOP = (N > DIGITS) ? (N - DIGITS) : 0;
   localparam int CW  = $clog2(TICK_DIV);

   typedef enum logic [1:0] {EMPTY, HOLD, SCROLL} state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   hex_q, hex_d;
   logic [DIGITS-1:0]     valid_q, valid_d;
   logic                  loaded_q, loaded_d;
   logic                  adv;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      adv     = 1'b0;
      if (clear) begin
         state_d = EMPTY;
         data_d  = '0;
         pos_d   = '0;
         cnt_d   = '0;
      end else if (load) begin
         data_d  = data_in;
         pos_d   = PW'(TOP);
         cnt_d   = auto_scroll ? CW'(TICK_DIV - 1) : '0;
         state_d = auto_scroll ? SCROLL : HOLD;
      end else begin
         case (state_q)
            HOLD: begin
               adv = step;
               if (auto_scroll) begin
                  state_d = SCROLL;
                  cnt_d   = CW'(TICK_DIV - 1);
               end
            end
            SCROLL: begin
               // Down-counter: terminal count 0 is the tick; a step reloads it so step+tick advances once.
               if (!auto_scroll) begin
                  state_d = HOLD;
                  cnt_d   = '0;
                  adv     = step;
               end else if (step || cnt_q == '0) begin
                  adv   = 1'b1;
                  cnt_d = CW'(TICK_DIV - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (adv)
         pos_d = (pos_q == '0) ? PW'(TOP) : pos_q - 1'b1;

      hex_d    = '0;
      valid_d  = '0;
      loaded_d = (state_d != EMPTY);
      for (int d = 0; d < DIGITS; d++) begin
         if (state_d != EMPTY && (int'(pos_d) + d) < N) begin
            hex_d[4*d +: 4] = data_d[4*(int'(pos_d) + d) +: 4];
            valid_d[d]      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         data_q   <= '0;
         pos_q    <= '0;
         cnt_q    <= '0;
         hex_q    <= '0;
         valid_q  <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         pos_q    <= pos_d;
         cnt_q    <= cnt_d;
         hex_q    <= hex_d;
         valid_q  <= valid_d;
         loaded_q <= loaded_d;
      end
   end

   assign hex_digits  = hex_q;
   assign digit_valid = valid_q;
   assign window_pos  = pos_q;
   assign loaded      = loaded_q;

endmodule

// File: tb/tb_hex_display_pager.sv
// Scoreboard bench: a 64-bit pager (A) and a 16-bit pager (B), expectations queued by cycle.
module tb_hex_display_pager;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        load_a, clear_a, step_a, auto_a;
   logic [63:0] data_a;
   logic [23:0] hex_a;
   logic [5:0]  valid_a;
   logic [3:0]  pos_a;
   logic        loaded_a;

   logic        load_b, clear_b, step_b, auto_b;
   logic [15:0] data_b;
   logic [23:0] hex_b;
   logic [5:0]  valid_b;
   logic [1:0]  pos_b;
   logic        loaded_b;

   hex_display_pager #(.DATA_W(64), .DIGITS(6), .TICK_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load_a), .data_in(data_a), .clear(clear_a),
      .step(step_a), .auto_scroll(auto_a), .hex_digits(hex_a), .digit_valid(valid_a),
      .window_pos(pos_a), .loaded(loaded_a));

   hex_display_pager #(.DATA_W(16), .DIGITS(6), .TICK_DIV(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load_b), .data_in(data_b), .clear(clear_b),
      .step(step_b), .auto_scroll(auto_b), .hex_digits(hex_b), .digit_valid(valid_b),
      .window_pos(pos_b), .loaded(loaded_b));

   typedef struct {
      int          cyc;
      int          dut;
      string       name;
      int          pos;
      logic [23:0] hex;
      logic [5:0]  valid;
      logic        loaded;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [63:0] held_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int dly, input int dut, input string name, input int pos,
                       input logic [23:0] hex, input logic [5:0] valid, input logic ld);
      exp_t e;
      e.cyc = cyc + dly; e.dut = dut; e.name = name; e.pos = pos;
      e.hex = hex; e.valid = valid; e.loaded = ld;
      sb.push_back(e);
   endtask

   // Window model: rightmost displayed nibble is pos, so shift the value down by pos nibbles.
   task automatic push_a(input int dly, input string name, input int pos);
      logic [63:0] sh;
      sh = held_a >> (4 * pos);
      push(dly, 0, name, pos, sh[23:0], 6'h3F, 1'b1);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) next();
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         int          gp;
         logic [23:0] gh;
         logic [5:0]  gv;
         logic        gl;
         mon_e = sb.pop_front();
         gp = (mon_e.dut == 0) ? int'(pos_a) : int'(pos_b);
         gh = (mon_e.dut == 0) ? hex_a : hex_b;
         gv = (mon_e.dut == 0) ? valid_a : valid_b;
         gl = (mon_e.dut == 0) ? loaded_a : loaded_b;
         total++;
         if (mon_e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: check missed, at cycle %0d but wanted cycle %0d", mon_e.name, cyc, mon_e.cyc);
         end else if (gp != mon_e.pos || gh !== mon_e.hex || gv !== mon_e.valid || gl !== mon_e.loaded) begin
            bad++;
            $display("FAIL %s: got pos=%0d hex=%h valid=%b loaded=%b, need pos=%0d hex=%h valid=%b loaded=%b",
                     mon_e.name, gp, gh, gv, gl, mon_e.pos, mon_e.hex, mon_e.valid, mon_e.loaded);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int L;
      int X;
      rst_n = 1'b0;
      load_a = 0; clear_a = 0; step_a = 0; auto_a = 0; data_a = '0;
      load_b = 0; clear_b = 0; step_b = 0; auto_b = 0; data_b = '0;
      held_a = 64'h0123456789ABCDEF;
      repeat (3) next();
      push(0, 0, "reset_a", 0, 24'h0, 6'h0, 1'b0);
      push(0, 1, "reset_b", 0, 24'h0, 6'h0, 1'b0);
      next();
      rst_n = 1'b1;

      // Idle with step pulses while empty
      for (int i = 0; i < 5; i++) begin
         step_a = 1'b1;
         if (i == 1 || i == 4) push(1, 0, "empty_step", 0, 24'h0, 6'h0, 1'b0);
         next();
         step_a = 1'b0;
         next();
      end

      data_a = held_a;
      load_a = 1'b1;
      push(1, 0, "load_hold", 10, 24'h012345, 6'h3F, 1'b1);
      next();
      load_a = 1'b0;
      data_a = 64'hFFFF_FFFF_FFFF_FFFF;
      next();

      for (int i = 1; i <= 11; i++) begin
         step_a = 1'b1;
         case (i)
            1:       push(1, 0, "step1", 9, 24'h123456, 6'h3F, 1'b1);
            10:      push(1, 0, "step10", 0, 24'hABCDEF, 6'h3F, 1'b1);
            11:      push(1, 0, "step11_wrap", 10, 24'h012345, 6'h3F, 1'b1);
            default: push_a(1, "step_mid", 10 - i);
         endcase
         next();
         step_a = 1'b0;
         next();
      end

      // Timed scroll with TICK_DIV = 4
      data_a = held_a;
      auto_a = 1'b1;
      load_a = 1'b1;
      L = cyc + 1;
      push_a(1, "scr_load", 10);
      push_a(4, "scr_pre_tick1", 10);
      push_a(5, "scr_tick1", 9);
      push_a(8, "scr_pre_tick2", 9);
      push_a(9, "scr_tick2", 8);
      next();
      load_a = 1'b0;
      wait_to(L + 9);
      step_a = 1'b1;
      push_a(1, "scr_step", 7);
      push_a(4, "scr_after_step_pre", 7);
      push_a(5, "scr_after_step_tick", 6);
      next();
      step_a = 1'b0;
      wait_to(L + 17);
      step_a = 1'b1;
      push_a(1, "scr_step_on_tick", 5);
      push_a(2, "scr_step_on_tick_hold", 5);
      push_a(4, "scr_pre_tick4", 5);
      push_a(5, "scr_tick4", 4);
      next();
      step_a = 1'b0;
      wait_to(L + 23);
      auto_a = 1'b0;
      push_a(7, "fall_hold", 4);
      wait_to(L + 31);

      // Enter scroll, then clear beats load in the same cycle
      auto_a = 1'b1;
      next();
      load_a = 1'b1; clear_a = 1'b1;
      push(1, 0, "load_clear", 0, 24'h0, 6'h0, 1'b0);
      next();
      load_a = 1'b0; clear_a = 1'b0; auto_a = 1'b0;
      next();
      load_a = 1'b1; step_a = 1'b1;
      push_a(1, "load_step", 10);
      next();
      load_a = 1'b0; step_a = 1'b0;

      // Value narrower than the display
      data_b = 16'hBEEF;
      auto_b = 1'b1;
      load_b = 1'b1;
      push(1, 1, "b_load", 0, 24'h00BEEF, 6'b001111, 1'b1);
      push(9, 1, "b_after_ticks", 0, 24'h00BEEF, 6'b001111, 1'b1);
      next();
      load_b = 1'b0;
      data_b = 16'h1234;
      repeat (9) next();
      step_b = 1'b1;
      push(1, 1, "b_step", 0, 24'h00BEEF, 6'b001111, 1'b1);
      next();
      step_b = 1'b0;

      // HOLD -> SCROLL on auto_scroll rising, then asynchronous reset mid-scroll
      auto_a = 1'b1;
      X = cyc + 1;
      push_a(4, "rise_pre_tick", 10);
      push_a(5, "rise_tick", 9);
      wait_to(X + 5);
      #2;
      rst_n = 1'b0;
      push(0, 0, "async_rst_a", 0, 24'h0, 6'h0, 1'b0);
      push(0, 1, "async_rst_b", 0, 24'h0, 6'h0, 1'b0);
      next();
      next();

      if (sb.size() != 0) begin
         $display("FAIL leftover: %0d expectations never checked, need 0", sb.size());
         total += sb.size();
         bad += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
